// File: rtl/garage_pkg.sv
//-----------------------------------------------------------------------------
// garage_pkg
// Shared garage-door constants: default timing for the input conditioner,
// channel indices used to address the three conditioned inputs, and the
// state encoding of the door FSM that consumes the conditioned signals.
// No ports (package).
//-----------------------------------------------------------------------------
package garage_pkg;

  // Conditioner timing defaults
  localparam int DB_CYCLES_DEFAULT      = 4;  // stable samples before a level flips
  localparam int LOCKOUT_CYCLES_DEFAULT = 8;  // press-ignore window after a pulse
  localparam int CNT_W_DEFAULT          = 8;  // debounce / lockout counter width

  // Conditioned input channels
  localparam int NUM_CHANNELS = 3;
  localparam int CH_BTN       = 0;
  localparam int CH_UP        = 1;
  localparam int CH_DN        = 2;

  // Door FSM state encoding
  typedef enum logic [2:0] {
    DOOR_CLOSED          = 3'd0,
    DOOR_OPENING         = 3'd1,
    DOOR_OPEN            = 3'd2,
    DOOR_CLOSING         = 3'd3,
    DOOR_STOPPED_OPENING = 3'd4,
    DOOR_STOPPED_CLOSING = 3'd5
  } door_state_e;

endpackage

// File: rtl/debounce_cell.sv
//-----------------------------------------------------------------------------
// debounce_cell
// Two-flop synchronizer followed by a counting debouncer for one bouncing
// asynchronous contact. The debounced level only changes after DB_CYCLES
// consecutive synchronized samples disagree with it; any agreeing sample in
// between restarts the count. Raw edge to o_level latency is DB_CYCLES+2.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   i_raw    in   asynchronous raw contact
//   o_level  out  debounced level (direct register output)
//-----------------------------------------------------------------------------
module debounce_cell
  import garage_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  // Count value at which the next disagreeing sample commits the new level.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  logic             w_level_next;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_level_next = r_level;
    w_cnt_next   = '0;
    if (r_sync2 != r_level) begin
      if (r_cnt == LP_CNT_LAST) begin
        // Enough consecutive disagreeing samples: adopt the new level.
        w_level_next = r_sync2;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + LP_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_level <= w_level_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/garage_input_conditioner.sv
//-----------------------------------------------------------------------------
// garage_input_conditioner
// Conditions the wall button and the two door limit switches for the door
// FSM. Each raw contact is synchronized and debounced in its own
// debounce_cell. The debounced button's rising edge becomes a single-cycle
// activate pulse, suppressed while a post-pulse lockout window is running or
// while both limits read active (sensor fault).
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   btn_raw     in   raw button / remote contact, 1 = pressed
//   up_lim_raw  in   raw fully-open limit, 1 = at limit
//   dn_lim_raw  in   raw fully-closed limit, 1 = at limit
//   activate    out  one-cycle press pulse
//   up_max      out  debounced up limit
//   dn_max      out  debounced down limit
//   lim_fault   out  registered, both debounced limits high
//-----------------------------------------------------------------------------
module garage_input_conditioner
  import garage_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic up_lim_raw,
  input  logic dn_lim_raw,
  output logic activate,
  output logic up_max,
  output logic dn_max,
  output logic lim_fault
);

  localparam logic [CNT_W-1:0] LP_LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] LP_LOCK_ONE  = CNT_W'(1);

  //---------------------------------------------------------------------------
  // Per-channel synchronize + debounce
  //---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] w_raw;
  logic [NUM_CHANNELS-1:0] w_level;

  assign w_raw[CH_BTN] = btn_raw;
  assign w_raw[CH_UP]  = up_lim_raw;
  assign w_raw[CH_DN]  = dn_lim_raw;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi = gi + 1) begin : g_chan
      debounce_cell #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (w_raw[gi]),
        .o_level (w_level[gi])
      );
    end
  endgenerate

  //---------------------------------------------------------------------------
  // Edge detect, lockout and fault
  //---------------------------------------------------------------------------
  logic             r_btn_prev;
  logic             r_activate;
  logic             r_fault;
  logic [CNT_W-1:0] r_lock;

  logic             w_rise;
  logic             w_accept;
  logic             w_fault_next;
  logic [CNT_W-1:0] w_lock_next;

  always_comb begin
    w_rise       = w_level[CH_BTN] & ~r_btn_prev;
    // The counter must already be zero; an edge arriving while it still
    // reads 1 is dropped even though it reaches zero at the same edge.
    w_accept     = w_rise & (r_lock == '0) & ~r_fault;
    w_fault_next = w_level[CH_UP] & w_level[CH_DN];
    w_lock_next  = r_lock;
    if (w_accept) begin
      w_lock_next = LP_LOCK_LOAD;
    end else if (r_lock != '0) begin
      w_lock_next = r_lock - LP_LOCK_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_prev <= 1'b0;
      r_activate <= 1'b0;
      r_fault    <= 1'b0;
      r_lock     <= '0;
    end else begin
      r_btn_prev <= w_level[CH_BTN];
      r_activate <= w_accept;
      r_fault    <= w_fault_next;
      r_lock     <= w_lock_next;
    end
  end

  assign activate  = r_activate;
  assign up_max    = w_level[CH_UP];
  assign dn_max    = w_level[CH_DN];
  assign lim_fault = r_fault;

endmodule

// File: tb/tb_garage_input_conditioner.sv
//-----------------------------------------------------------------------------
// tb_garage_input_conditioner
// Directed scenarios with literal expectations plus a randomized run, all
// compared every cycle against a behavioural model: a level flips once the
// last DB synchronized samples all disagree with it, a pulse is accepted on a
// debounced rising edge when the previous pulse is more than LK edges old and
// no fault is registered.
//-----------------------------------------------------------------------------
module tb_garage_input_conditioner;

  localparam int DB = 4;
  localparam int LK = 8;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic btn_raw    = 1'b0;
  logic up_lim_raw = 1'b0;
  logic dn_lim_raw = 1'b0;
  logic activate;
  logic up_max;
  logic dn_max;
  logic lim_fault;

  int n_checks  = 0;
  int n_pass    = 0;
  int act_count = 0;

  garage_input_conditioner #(
    .DB_CYCLES      (DB),
    .LOCKOUT_CYCLES (LK),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .up_lim_raw (up_lim_raw),
    .dn_lim_raw (dn_lim_raw),
    .activate   (activate),
    .up_max     (up_max),
    .dn_max     (dn_max),
    .lim_fault  (lim_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t",
                  name, $signed(actual), $signed(expected), $time);
  endtask

  //---------------------------------------------------------------------------
  // Behavioural model (updated on each rising edge from the sampled inputs)
  //---------------------------------------------------------------------------
  bit m_hist [3][DB+1];   // raw samples of previous edges, [0] newest
  bit m_lvl  [3];
  bit m_raw  [3];
  bit m_btn_prev, m_act, m_fault, m_pulsed, m_valid;
  bit m_rise, m_take, m_cand, m_ok;
  int m_cyc = 0;
  int m_last_pulse = 0;

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      m_cyc++;
      m_raw[0] = btn_raw;
      m_raw[1] = up_lim_raw;
      m_raw[2] = dn_lim_raw;
      if (rst) begin
        for (int ch = 0; ch < 3; ch++) begin
          m_lvl[ch] = 1'b0;
          for (int k = 0; k <= DB; k++) m_hist[ch][k] = 1'b0;
        end
        m_btn_prev = 1'b0;
        m_act      = 1'b0;
        m_fault    = 1'b0;
        m_pulsed   = 1'b0;
        m_valid    = 1'b1;
      end else begin
        m_rise = m_lvl[0] && !m_btn_prev;
        m_take = m_rise && !m_fault &&
                 (!m_pulsed || (m_cyc - m_last_pulse) > LK);
        m_btn_prev = m_lvl[0];
        m_fault    = m_lvl[1] && m_lvl[2];
        m_act      = m_take;
        if (m_take) begin
          m_pulsed     = 1'b1;
          m_last_pulse = m_cyc;
        end
        for (int ch = 0; ch < 3; ch++) begin
          // Samples reaching the debouncer now are those taken 2..DB+1 edges ago.
          m_cand = !m_lvl[ch];
          m_ok   = 1'b1;
          for (int k = 1; k <= DB; k++)
            if (m_hist[ch][k] != m_cand) m_ok = 1'b0;
          if (m_ok) m_lvl[ch] = m_cand;
          for (int k = DB; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
          m_hist[ch][0] = m_raw[ch];
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("activate",  activate,  m_act);
        check("up_max",    up_max,    m_lvl[1]);
        check("dn_max",    dn_max,    m_lvl[2]);
        check("lim_fault", lim_fault, m_fault);
      end
    end
  end

  // Pulse counter, sampled just after the edge to stay clear of the stimulus
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (activate === 1'b1) act_count++;
    end
  end

  //---------------------------------------------------------------------------
  // Helpers
  //---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch_act(input int n, output int first, output int count);
    first = -1;
    count = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (activate === 1'b1) begin
        if (first < 0) first = i;
        count++;
      end
    end
  endtask

  // which: 0 = up_max, 1 = dn_max, 2 = lim_fault
  task automatic watch_level(input int n, input int which, input logic want,
                             output int first);
    logic cur;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cur = (which == 0) ? up_max : (which == 1) ? dn_max : lim_fault;
      if (cur === want && first < 0) first = i;
    end
  endtask

  //---------------------------------------------------------------------------
  // Stimulus
  //---------------------------------------------------------------------------
  int f, c, c0, hi;
  bit tgt [3];

  initial begin
    // Reset state
    idle(3);
    check("rst_activate",  activate,  0);
    check("rst_up_max",    up_max,    0);
    check("rst_dn_max",    dn_max,    0);
    check("rst_lim_fault", lim_fault, 0);
    rst = 1'b0;
    idle(5);

    // Clean press held 20 cycles
    btn_raw = 1'b1;
    watch_act(20, f, c);
    check("clean_latency", f, 7);
    check("clean_pulses",  c, 1);
    btn_raw = 1'b0;
    idle(15);

    // Bounce: 6 cycles toggling, then held
    c0 = act_count;
    for (int i = 0; i < 6; i++) begin
      btn_raw = (i % 2 == 0);
      @(negedge clk);
    end
    btn_raw = 1'b1;
    watch_act(20, f, c);
    check("bounce_latency", f, 7);
    check("bounce_pulses", act_count - c0, 1);
    btn_raw = 1'b0;
    idle(15);

    // Lockout: debounced rising edges 8 apart -> second dropped
    c0 = act_count;
    btn_raw = 1'b1; idle(4);
    btn_raw = 1'b0; idle(4);
    btn_raw = 1'b1; idle(20);
    check("lockout_8_pulses", act_count - c0, 1);
    btn_raw = 1'b0;
    idle(20);

    // Edges 9 apart -> both accepted
    c0 = act_count;
    btn_raw = 1'b1; idle(4);
    btn_raw = 1'b0; idle(5);
    btn_raw = 1'b1; idle(20);
    check("lockout_9_pulses", act_count - c0, 2);
    btn_raw = 1'b0;
    idle(15);

    // Down limit held through reset
    c0 = act_count;
    rst = 1'b1;
    dn_lim_raw = 1'b1;
    idle(2);
    rst = 1'b0;
    watch_level(20, 1, 1'b1, f);
    check("dn_max_latency", f, 6);

    // 3-cycle glitch on the up limit
    up_lim_raw = 1'b1;
    hi = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 3) up_lim_raw = 1'b0;
      if (up_max === 1'b1) hi++;
    end
    check("up_glitch_cycles_high", hi, 0);
    check("limit_no_spurious_pulse", act_count - c0, 0);

    // Fault: both limits, press ignored, release clears after 7
    up_lim_raw = 1'b1;
    watch_level(20, 2, 1'b1, f);
    check("fault_set_latency", f, 7);
    c0 = act_count;
    btn_raw = 1'b1;
    idle(20);
    check("fault_level_held", lim_fault, 1);
    up_lim_raw = 1'b0;
    watch_level(20, 2, 1'b0, f);
    check("fault_clear_latency", f, 7);
    idle(5);
    check("fault_press_pulses", act_count - c0, 0);
    btn_raw    = 1'b0;
    dn_lim_raw = 1'b0;
    idle(15);

    // Reset two cycles after a pulse
    btn_raw = 1'b1;
    f = -1;
    for (int i = 1; i <= 20 && f < 0; i++) begin
      @(negedge clk);
      if (activate === 1'b1) f = i;
    end
    check("pre_reset_latency", f, 7);
    idle(2);
    rst = 1'b1;
    btn_raw = 1'b0;
    @(negedge clk);
    check("midrst_activate",  activate,  0);
    check("midrst_up_max",    up_max,    0);
    check("midrst_dn_max",    dn_max,    0);
    check("midrst_lim_fault", lim_fault, 0);
    rst = 1'b0;
    btn_raw = 1'b1;
    watch_act(20, f, c);
    check("post_reset_latency", f, 7);
    check("post_reset_pulses",  c, 1);
    btn_raw = 1'b0;
    idle(15);

    // Randomized run: slowly changing targets with short glitches
    for (int ch = 0; ch < 3; ch++) tgt[ch] = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) tgt[0] = !tgt[0];
      if ($urandom_range(0, 39) == 0) tgt[1] = !tgt[1];
      if ($urandom_range(0, 39) == 0) tgt[2] = !tgt[2];
      btn_raw    = ($urandom_range(0, 9)  == 0) ? !tgt[0] : tgt[0];
      up_lim_raw = ($urandom_range(0, 14) == 0) ? !tgt[1] : tgt[1];
      dn_lim_raw = ($urandom_range(0, 14) == 0) ? !tgt[2] : tgt[2];
      rst        = ($urandom_range(0, 599) == 0);
    end
    rst        = 1'b0;
    btn_raw    = 1'b0;
    up_lim_raw = 1'b0;
    dn_lim_raw = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
